// File: rtl/mem_bus_checker.sv
// mem_bus_checker: passive monitor for the processor/external-memory bus.
// An in-order scoreboard of expected writes is loaded while idle. A run then
// checks every observed write against it and ends with a registered verdict:
// PASS on kraj with every entry matched, or FAIL with a reason code.
// Optional build macro CHK_RDCNT_EN adds a read counter and a running XOR of
// read data (read_count / rd_xor ports).
module mem_bus_checker #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] mar,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] memdata,
  input  logic             kraj,
  input  logic             exp_load,
  input  logic [WIDTH-1:0] exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err_code,
  output logic [CNTW-1:0]  write_count,
  output logic [CNTW-1:0]  cycle_count
`ifdef CHK_RDCNT_EN
  ,
  output logic [CNTW-1:0]  read_count,
  output logic [WIDTH-1:0] rd_xor
`endif
);

  // PW holds 0..DEPTH; IW indexes a power-of-two sized table.
  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SZ = 1 << IW;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MISM    = 2'b01;
  localparam logic [1:0] ERR_MISSING = 2'b10;
  localparam logic [1:0] ERR_TO_XTRA = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;

  state_e            state_q;
  logic [PW-1:0]     exp_count_q;
  logic [PW-1:0]     ptr_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [1:0]        err_q;
  logic [CNTW-1:0]   write_count_q;
  logic [CNTW-1:0]   cycle_count_q;
  logic [WIDTH-1:0]  tab_addr_q [SZ];
  logic [WIDTH-1:0]  tab_data_q [SZ];

  logic              load_ok;
  logic              start_ok;
  logic [PW-1:0]     ptr_d;
  logic [CNTW-1:0]   cycle_count_d;
  logic [CNTW-1:0]   write_count_d;
  logic              fin_d;
  logic              pass_d;
  logic [1:0]        err_d;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  assign load_ok  = (state_q == S_IDLE) && exp_load && (exp_count_q != PW'(DEPTH));
  assign start_ok = start && (state_q != S_RUN);

  // Evaluate one RUN cycle: timeout, then write check, then kraj, first failure wins.
  always_comb begin
    logic timeout;
    logic extra;
    logic mism;
    cycle_count_d = sat_inc(cycle_count_q);
    write_count_d = memwrite ? sat_inc(write_count_q) : write_count_q;
    timeout = (cycle_count_q == CNTW'(TIMEOUT - 1));
    extra   = memwrite && (ptr_q == exp_count_q);
    mism    = memwrite && !extra &&
              ((mar != tab_addr_q[ptr_q[IW-1:0]]) ||
               (writedata != tab_data_q[ptr_q[IW-1:0]]));
    ptr_d   = (memwrite && !extra && !mism) ? ptr_q + PW'(1) : ptr_q;
    fin_d   = 1'b0;
    pass_d  = 1'b0;
    err_d   = ERR_NONE;
    if (timeout || extra) begin
      fin_d = 1'b1;
      err_d = ERR_TO_XTRA;
    end else if (mism) begin
      fin_d = 1'b1;
      err_d = ERR_MISM;
    end else if (kraj) begin
      fin_d = 1'b1;
      if (ptr_d == exp_count_q) pass_d = 1'b1;
      else                      err_d  = ERR_MISSING;
    end
  end

  // Control FSM with registered verdict flags and run counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      exp_count_q   <= '0;
      ptr_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= ERR_NONE;
      write_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load_ok) exp_count_q <= exp_count_q + PW'(1);
        end
        S_RUN: begin
          cycle_count_q <= cycle_count_d;
          write_count_q <= write_count_d;
          ptr_q         <= ptr_d;
          if (fin_d) begin
            state_q <= pass_d ? S_PASS : S_FAIL;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= pass_d;
            err_q   <= err_d;
          end
        end
        default: ;
      endcase
      if (start_ok) begin
        state_q       <= S_RUN;
        busy_q        <= 1'b1;
        done_q        <= 1'b0;
        pass_q        <= 1'b0;
        err_q         <= ERR_NONE;
        ptr_q         <= '0;
        write_count_q <= '0;
        cycle_count_q <= '0;
      end
    end
  end

  // Scoreboard table storage; contents are only meaningful below exp_count.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      tab_addr_q[exp_count_q[IW-1:0]] <= exp_addr;
      tab_data_q[exp_count_q[IW-1:0]] <= exp_data;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_code    = err_q;
  assign write_count = write_count_q;
  assign cycle_count = cycle_count_q;

`ifdef CHK_RDCNT_EN
  logic [CNTW-1:0]  read_count_q;
  logic [WIDTH-1:0] rd_xor_q;

  // Read activity statistics for the current run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_count_q <= '0;
      rd_xor_q     <= '0;
    end else if (start_ok) begin
      read_count_q <= '0;
      rd_xor_q     <= '0;
    end else if ((state_q == S_RUN) && memread) begin
      read_count_q <= sat_inc(read_count_q);
      rd_xor_q     <= rd_xor_q ^ memdata;
    end
  end

  assign read_count = read_count_q;
  assign rd_xor     = rd_xor_q;
`else
  // Read-side inputs are only observed when read statistics are built in.
  logic unused_rd;
  assign unused_rd = ^{memread, memdata};
`endif

endmodule

// File: tb/tb_mem_bus_checker.sv
// Self-checking bench for mem_bus_checker: directed scenarios plus random
// runs, compared each cycle against a queue-based reference model.
module tb_mem_bus_checker;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int CNTW    = 16;
  localparam int CMAX    = (1 << CNTW) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             memread = 1'b0, memwrite = 1'b0, kraj = 1'b0;
  logic             exp_load = 1'b0, start = 1'b0;
  logic [WIDTH-1:0] mar = '0, writedata = '0, memdata = '0;
  logic [WIDTH-1:0] exp_addr = '0, exp_data = '0;
  logic             busy, done, pass;
  logic [1:0]       err_code;
  logic [CNTW-1:0]  write_count, cycle_count;
`ifdef CHK_RDCNT_EN
  logic [CNTW-1:0]  read_count;
  logic [WIDTH-1:0] rd_xor;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: modes 0 idle, 1 run, 2 pass, 3 fail.
  int               m_mode;
  logic [15:0]      m_exp[$];
  logic [15:0]      m_pend[$];
  int               m_cyc, m_wc, m_rc, m_err;
  logic [WIDTH-1:0] m_rx;

  mem_bus_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .mar(mar), .writedata(writedata), .memdata(memdata), .kraj(kraj),
    .exp_load(exp_load), .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code),
    .write_count(write_count), .cycle_count(cycle_count)
`ifdef CHK_RDCNT_EN
    , .read_count(read_count), .rd_xor(rd_xor)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v + 1 > CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_exp.delete(); m_pend.delete();
    m_cyc = 0; m_wc = 0; m_rc = 0; m_err = 0; m_rx = '0;
  endtask

  task automatic model_begin_run();
    m_mode = 1; m_pend = m_exp;
    m_cyc = 0; m_wc = 0; m_rc = 0; m_err = 0; m_rx = '0;
  endtask

  task automatic model_fail(input int e);
    m_mode = 3; m_err = e;
  endtask

  // Apply one clock edge worth of the rules to the model, using the driven inputs.
  task automatic model_step();
    case (m_mode)
      0: begin
        if (exp_load && m_exp.size() < DEPTH) m_exp.push_back({exp_addr, exp_data});
        if (start) model_begin_run();
      end
      1: begin
        m_cyc = sat(m_cyc);
        if (memwrite) m_wc = sat(m_wc);
        if (memread) begin m_rc = sat(m_rc); m_rx = m_rx ^ memdata; end
        if (m_cyc == TIMEOUT) model_fail(3);
        else if (memwrite && m_pend.size() == 0) model_fail(3);
        else if (memwrite && m_pend[0] != {mar, writedata}) model_fail(1);
        else begin
          if (memwrite) void'(m_pend.pop_front());
          if (kraj) begin
            if (m_pend.size() == 0) m_mode = 2;
            else model_fail(2);
          end
        end
      end
      default: if (start) model_begin_run();
    endcase
  endtask

  task automatic compare_all();
    chk("busy", busy, m_mode == 1);
    chk("done", done, m_mode >= 2);
    chk("pass", pass, m_mode == 2);
    chk("err_code", err_code, m_err);
    chk("write_count", write_count, m_wc);
    chk("cycle_count", cycle_count, m_cyc);
`ifdef CHK_RDCNT_EN
    chk("read_count", read_count, m_rc);
    chk("rd_xor", rd_xor, m_rx);
`endif
  endtask

  task automatic clear_inputs();
    memread = 0; memwrite = 0; kraj = 0; exp_load = 0; start = 0;
  endtask

  // One clock: inputs already driven; update model, sample after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] d);
    exp_load = 1; exp_addr = a; exp_data = d; tick();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic kj);
    memwrite = 1; mar = a; writedata = d; kraj = kj; tick();
  endtask

  task automatic do_start();
    start = 1; tick();
  endtask

  task automatic do_kraj();
    kraj = 1; tick();
  endtask

  task automatic do_read(input logic [7:0] d);
    memread = 1; memdata = d; tick();
  endtask

  initial begin
    #1;
    do_reset();

    // T1: two matching writes then kraj -> PASS.
    do_load(8'd10, 8'd7); do_load(8'd76, 8'd7); do_start();
    chk("t1_busy", busy, 1);
    do_write(8'd10, 8'd7, 0); do_write(8'd76, 8'd7, 0); do_kraj();
    chk("t1_pass", pass, 1); chk("t1_err", err_code, 0); chk("t1_wc", write_count, 2);

    // T2: data mismatch -> FAIL 01, later kraj ignored.
    do_reset();
    do_load(8'd76, 8'd7); do_start();
    do_write(8'd76, 8'd8, 0);
    chk("t2_done", done, 1); chk("t2_err", err_code, 1);
    do_kraj();
    chk("t2_done_hold", done, 1); chk("t2_err_hold", err_code, 1);

    // T3: kraj with a write missing -> FAIL 10; restart keeps the table.
    do_reset();
    do_load(8'd10, 8'd7); do_load(8'd76, 8'd7); do_start();
    do_write(8'd10, 8'd7, 0); do_kraj();
    chk("t3_err", err_code, 2); chk("t3_pass", pass, 0);
    do_start();
    chk("t3_busy", busy, 1); chk("t3_cyc0", cycle_count, 0); chk("t3_wc0", write_count, 0);
    do_write(8'd10, 8'd7, 0); do_write(8'd76, 8'd7, 0); do_kraj();
    chk("t3_repass", pass, 1);

    // T4: timeout, also with a matching write and kraj on the last cycle.
    do_reset();
    do_start();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("t4_still_busy", busy, 1);
    tick();
    chk("t4_err", err_code, 3); chk("t4_cyc", cycle_count, TIMEOUT);
    do_reset();
    do_load(8'd10, 8'd7); do_start();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    do_write(8'd10, 8'd7, 1);
    chk("t4b_err", err_code, 3); chk("t4b_pass", pass, 0);

    // T5: load beyond DEPTH ignored; final match with kraj -> PASS; extra write -> 11.
    do_reset();
    do_load(8'd1, 8'd1); do_load(8'd2, 8'd2); do_load(8'd3, 8'd3);
    do_load(8'd76, 8'd7); do_load(8'd9, 8'd9);
    do_start();
    do_write(8'd1, 8'd1, 0); do_write(8'd2, 8'd2, 0); do_write(8'd3, 8'd3, 0);
    do_write(8'd76, 8'd7, 1);
    chk("t5_pass", pass, 1);
    do_start();
    do_write(8'd1, 8'd1, 0); do_write(8'd2, 8'd2, 0); do_write(8'd3, 8'd3, 0);
    do_write(8'd76, 8'd7, 0); do_write(8'd9, 8'd9, 0);
    chk("t5_extra_err", err_code, 3);

    // T6: reads during a run, then asynchronous reset between edges.
    do_reset();
    do_load(8'd5, 8'd5); do_start();
    do_read(8'h0F); do_read(8'hF0); do_read(8'h01);
`ifdef CHK_RDCNT_EN
    chk("t6_rc", read_count, 3); chk("t6_rx", rd_xor, 8'hFE);
`endif
    chk("t6_busy_pre", busy, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_busy", busy, 0); chk("t6_done", done, 0); chk("t6_pass", pass, 0);
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
    do_write(8'd5, 8'd5, 1);
    chk("t6_idle_after", busy, 0);
    // Table was cleared: an empty run passes on kraj.
    do_start(); do_kraj();
    chk("t6_empty_pass", pass, 1);

    // Random runs.
    for (int r = 0; r < 60; r++) begin
      int nl;
      do_reset();
      nl = $urandom_range(0, 6);
      for (int k = 0; k < nl; k++) begin
        exp_load = 1;
        exp_addr = 8'($urandom_range(0, 7));
        exp_data = 8'($urandom_range(0, 3));
        start = (k == nl - 1) && ($urandom_range(0, 1) == 1);
        tick();
      end
      if (m_mode == 0) do_start();
      for (int c = 0; c < 14; c++) begin
        memread  = ($urandom_range(0, 2) == 0);
        memdata  = 8'($urandom);
        memwrite = ($urandom_range(0, 2) == 0);
        if (memwrite && m_pend.size() > 0 && $urandom_range(0, 3) != 0) begin
          mar = m_pend[0][15:8]; writedata = m_pend[0][7:0];
        end else begin
          mar = 8'($urandom_range(0, 7)); writedata = 8'($urandom_range(0, 3));
        end
        kraj     = ($urandom_range(0, 5) == 0);
        start    = ($urandom_range(0, 9) == 0);
        exp_load = ($urandom_range(0, 7) == 0);
        exp_addr = 8'($urandom); exp_data = 8'($urandom);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
